// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the flag bundle.
package alu_pkg;

    localparam logic [2:0] OPC_ADD = 3'b000;
    localparam logic [2:0] OPC_SUB = 3'b001;
    localparam logic [2:0] OPC_AND = 3'b010;
    localparam logic [2:0] OPC_OR  = 3'b011;
    localparam logic [2:0] OPC_XOR = 3'b100;
    localparam logic [2:0] OPC_SHL = 3'b101;
    localparam logic [2:0] OPC_SHR = 3'b110;
    localparam logic [2:0] OPC_MUL = 3'b111;

    typedef enum logic [2:0] {
        OP_ADD = OPC_ADD,
        OP_SUB = OPC_SUB,
        OP_AND = OPC_AND,
        OP_OR  = OPC_OR,
        OP_XOR = OPC_XOR,
        OP_SHL = OPC_SHL,
        OP_SHR = OPC_SHR,
        OP_MUL = OPC_MUL
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_e;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic s;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial-product step per cycle.
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;

    // product presents the post-step sum so the final step and the capture share one edge
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign product = acc_nxt;
    assign done    = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            cnt    <= CW'(WIDTH);
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (cnt != '0) begin
            cnt    <= cnt - CW'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nxt;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered 8-op ALU with valid/ready on both sides and a multi-cycle multiply.
// Optional: define ALU_SEQ_SAT_EN to saturate ADD/SUB on signed overflow.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             S
);

    localparam int SH_W = CNT_W - 1;

    alu_state_e         state, state_nxt;
    alu_op_e            op_e;
    logic               xfer;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    alu_flags_t         mul_flags;

    logic [WIDTH-1:0]   bx;
    logic [WIDTH:0]     sum;
    logic [SH_W-1:0]    amt;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH-1:0]   res_c;
    alu_flags_t         flg_c;

    logic [WIDTH-1:0]   result_q;
    alu_flags_t         flags_q;

    assign op_e      = alu_op_e'(op);
    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign xfer      = in_valid && in_ready;
    assign mul_start = xfer && (op_e == OP_MUL);

    assign bx  = (op_e == OP_SUB) ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, (op_e == OP_SUB)};
    assign amt = b[SH_W-1:0];
    // one guard bit beyond the operand catches the last bit shifted out for any amount
    assign shl_ext = {1'b0, a} << amt;
    assign shr_ext = {a, 1'b0} >> amt;

    always_comb begin
        res_c   = '0;
        flg_c   = '0;
        case (op_e)
            OP_ADD, OP_SUB: begin
                res_c   = sum[WIDTH-1:0];
                flg_c.c = sum[WIDTH];
                flg_c.v = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SEQ_SAT_EN
                if (flg_c.v)
                    res_c = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_XOR: res_c = a ^ b;
            OP_SHL: begin
                res_c   = shl_ext[WIDTH-1:0];
                flg_c.c = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res_c   = shr_ext[WIDTH:1];
                flg_c.c = shr_ext[0];
            end
            default: res_c = '0;
        endcase
        flg_c.z = (res_c == '0);
        flg_c.s = res_c[WIDTH-1];
    end

    always_comb begin
        mul_flags   = '0;
        mul_flags.z = (mul_prod[WIDTH-1:0] == '0);
        mul_flags.c = |mul_prod[2*WIDTH-1:WIDTH];
        mul_flags.s = mul_prod[WIDTH-1];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (xfer) state_nxt = (op_e == OP_MUL) ? BUSY : DONE;
            BUSY: if (mul_done) state_nxt = DONE;
            DONE: begin
                if (xfer)
                    state_nxt = (op_e == OP_MUL) ? BUSY : DONE;
                else if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state <= state_nxt;
            if (xfer && op_e != OP_MUL) begin
                result_q <= res_c;
                flags_q  <= flg_c;
            end else if (state == BUSY && mul_done) begin
                result_q <= mul_prod[WIDTH-1:0];
                flags_q  <= mul_flags;
            end
        end
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign result = result_q;
    assign Z      = flags_q.z;
    assign C      = flags_q.c;
    assign V      = flags_q.v;
    assign S      = flags_q.s;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed test-plan cases, then randomized traffic with backpressure.
module tb_alu_seq;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         Z, C, V, S;

    logic rand_ready = 1'b0;
    logic rnd_ready  = 1'b1;
    logic dir_ready  = 1'b0;
    assign out_ready = rand_ready ? rnd_ready : dir_ready;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   f;   // {Z,C,V,S}
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Z         (Z),
        .C         (C),
        .V         (V),
        .S         (S)
    );

    function automatic int to_signed(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    // Reference model from the arithmetic definition of each op
    function automatic exp_t model(input int o, input int x, input int y);
        int   r, c, v, sr, k;
        exp_t e;
        r = 0; c = 0; v = 0;
        k = y % (1 << $clog2(W));
        case (o)
            0: begin
                r  = (x + y) % M;
                c  = int'((x + y) >= M);
                sr = to_signed(x) + to_signed(y);
                v  = int'(sr > M / 2 - 1 || sr < -(M / 2));
            end
            1: begin
                r  = (x + (M - 1 - y) + 1) % M;
                c  = int'((x + (M - 1 - y) + 1) >= M);
                sr = to_signed(x) - to_signed(y);
                v  = int'(sr > M / 2 - 1 || sr < -(M / 2));
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin
                r = (x << k) % M;
                c = (k == 0 || k > W) ? 0 : (x >> (W - k)) & 1;
            end
            6: begin
                r = x >> k;
                c = (k == 0) ? 0 : (x >> (k - 1)) & 1;
            end
            default: begin
                r = (x * y) % M;
                c = int'((x * y) >= M);
            end
        endcase
`ifdef ALU_SEQ_SAT_EN
        if (o <= 1 && v != 0)
            r = (to_signed(x) < 0) ? M / 2 : M / 2 - 1;
`endif
        e.res = W'(r);
        e.f   = {r == 0, c != 0, v != 0, ((r >> (W - 1)) & 1) != 0};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented output must match the scoreboard head; pop on consume
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%0h required=none", {result, Z, C, V, S});
                end else begin
                    chk("sb_result_flags", 32'({result, Z, C, V, S}), 32'({sb[0].res, sb[0].f}));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(int'(o), int'(x), int'(y)));
                done = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_in_ready required=in_ready_within_50");
        end
    endtask

    task automatic expect_now(input string name, input logic [W-1:0] r, input logic [3:0] f);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk(name, 32'({result, Z, C, V, S}), 32'({r, f}));
        @(posedge clk);
        #1;
    endtask

    task automatic mul_timed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] r, input logic [3:0] f);
        issue(3'b111, x, y);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            chk({name, "_busy_valid"}, 32'(out_valid), 32'd0);
            chk({name, "_busy_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        expect_now(name, r, f);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result_flags", 32'({result, Z, C, V, S}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dir_ready = 1'b1;
        @(posedge clk);
        #1;

        issue(3'b000, 4'b1010, 4'b0110);
        expect_now("add_wrap", 4'b0000, 4'b1100);
        issue(3'b001, 4'b1010, 4'b0110);
        expect_now("sub_ovf", 4'b0100, 4'b0110);
        issue(3'b001, 4'b0001, 4'b0100);
        expect_now("sub_borrow", 4'b1101, 4'b0001);
        issue(3'b000, 4'b0111, 4'b0111);
`ifdef ALU_SEQ_SAT_EN
        expect_now("add_sat", 4'b0111, 4'b0010);
`else
        expect_now("add_ovf", 4'b1110, 4'b0011);
`endif
        mul_timed("mul_3x5", 4'b0011, 4'b0101, 4'b1111, 4'b0001);
        mul_timed("mul_5x5", 4'b0101, 4'b0101, 4'b1001, 4'b0101);
        issue(3'b110, 4'b1011, 4'b0000);
        expect_now("shr_zero_amt", 4'b1011, 4'b0001);

        dir_ready = 1'b0;
        issue(3'b010, 4'b1010, 4'b0110);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", 32'(result), 32'(4'b0010));
            @(posedge clk);
            #1;
        end
        dir_ready = 1'b1;
        issue(3'b011, 4'b1010, 4'b0110);
        expect_now("bp_or", 4'b1110, 4'b0001);

        issue(3'b111, 4'b0011, 4'b0101);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midmul_rst_valid", 32'(out_valid), 32'd0);
        chk("midmul_rst_ready", 32'(in_ready), 32'd1);
        chk("midmul_rst_result_flags", 32'({result, Z, C, V, S}), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(3'b101, 4'b1001, 4'b0001);
        expect_now("shl_after_rst", 4'b0010, 4'b0100);

        rand_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            issue(3'($urandom), W'($urandom), W'($urandom));
        end
        rand_ready = 1'b0;
        dir_ready = 1'b1;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
